// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory responder:
//   - DMCtrl access-size / extension encodings produced by decode
//   - FSM state constants (IDLE, ACC2, RESP)
//   - size_of(): number of bytes touched by a DMCtrl encoding
// -----------------------------------------------------------------------------
package dm_pkg;

    // DMCtrl encodings
    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    // FSM states {IDLE, ACC2, RESP}
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC2 = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Access size in bytes. Illegal encodings report 1 so that they never
    // look like a split; they are rejected by the error check anyway.
    function automatic logic [2:0] size_of(input logic [2:0] ctrl);
        logic [2:0] n;
        case (ctrl)
            DM_B, DM_BU: n = 3'd1;
            DM_H, DM_HU: n = 3'd2;
            DM_W:        n = 3'd4;
            default:     n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bundle between the pipeline (master) and the data-memory
// responder (slave).
//   req_valid/req_ready : request handshake
//   addr, wdata         : byte address and right-aligned store data
//   DMWR, DMCtrl        : store flag and size/extension encoding
//   rsp_valid           : one-cycle response pulse
//   rdata, err          : extended load data and rejection flag
// -----------------------------------------------------------------------------
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        DMWR;
    logic [2:0]  DMCtrl;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req_valid, addr, wdata, DMWR, DMCtrl,
        input  req_ready, rsp_valid, rdata, err
    );

    modport slave (
        input  req_valid, addr, wdata, DMWR, DMCtrl,
        output req_ready, rsp_valid, rdata, err
    );
endinterface

// File: rtl/dm_lane_align.sv
// -----------------------------------------------------------------------------
// dm_lane_align
// Combinational byte-lane aligner over the 64-bit view {word[idx+1], word[idx]}.
// Ports:
//   i_o      : byte offset inside the first word (addr[1:0])
//   i_ctrl   : DMCtrl encoding
//   i_wdata  : right-aligned store data
//   i_dword  : {w1, w0} read data
//   o_mask   : 8-bit byte-lane write mask, bit k = byte k of the 64-bit view
//   o_sdata  : store data shifted into its lanes
//   o_ldata  : load result, truncated to the access size and extended
// -----------------------------------------------------------------------------
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  i_o,
    input  logic [2:0]  i_ctrl,
    input  logic [31:0] i_wdata,
    input  logic [63:0] i_dword,
    output logic [7:0]  o_mask,
    output logic [63:0] o_sdata,
    output logic [31:0] o_ldata
);

    logic [3:0]  w_base;
    logic [4:0]  w_shamt;
    logic [31:0] w_sh;

    assign w_shamt = {i_o, 3'b000};

    // Unshifted lane mask for the access size
    always_comb begin
        w_base = 4'b0001;
        case (size_of(i_ctrl))
            3'd1:    w_base = 4'b0001;
            3'd2:    w_base = 4'b0011;
            3'd4:    w_base = 4'b1111;
            default: w_base = 4'b0001;
        endcase
    end

    assign o_mask  = 8'({4'b0000, w_base} << i_o);
    assign o_sdata = {32'h0000_0000, i_wdata} << w_shamt;

    // Only the low 32 bits of the shifted view can belong to the result
    assign w_sh = 32'(i_dword >> w_shamt);

    // Truncate to the access size and extend
    always_comb begin
        o_ldata = 32'h0000_0000;
        case (i_ctrl)
            DM_B:    o_ldata = {{24{w_sh[7]}},  w_sh[7:0]};
            DM_BU:   o_ldata = {24'h00_0000,    w_sh[7:0]};
            DM_H:    o_ldata = {{16{w_sh[15]}}, w_sh[15:0]};
            DM_HU:   o_ldata = {16'h0000,       w_sh[15:0]};
            DM_W:    o_ldata = w_sh;
            default: o_ldata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Data-memory responder executing decode-stage load/store commands against a
// local word-organised RAM. Byte/half/word accesses with sign/zero extension;
// accesses crossing a word boundary are split over two consecutive cycles.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : data_mem_ctrl_if.slave (request handshake, command, response)
// Parameters:
//   DEPTH_WORDS : number of 32-bit RAM words
//   IDX_W       : word-index width
// -----------------------------------------------------------------------------
module data_mem_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    data_mem_ctrl_if.slave   bus
);

    // RAM (not reset)
    logic [31:0] r_mem [DEPTH_WORDS];

    // FSM and response registers
    logic [1:0]  r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rdata;
    logic        r_err;

    // Request captured at acceptance, used by the ACC2 half of a split
    logic [1:0]       r_o;
    logic [2:0]       r_ctrl;
    logic             r_we;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_w0;
    logic [31:0]      r_wdata;

    // Decode of the live request
    logic [1:0]       w_o;
    logic [30:0]      w_idx_full;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_idx_hi;
    logic             w_split;
    logic             w_bad_ctrl;
    logic             w_bad_store;
    logic             w_oor;
    logic             w_oor_hi;
    logic             w_err;
    logic             w_accept;
    logic             w_wr_lo;
    logic             w_wr_hi;

    // Aligner inputs/outputs
    logic [1:0]  w_al_o;
    logic [2:0]  w_al_ctrl;
    logic [31:0] w_al_wdata;
    logic [63:0] w_al_dword;
    logic [7:0]  w_al_mask;
    logic [63:0] w_al_sdata;
    logic [31:0] w_al_ldata;
    logic [31:0] w_bm_lo;
    logic [31:0] w_bm_hi;
    logic [31:0] w_lo_word;
    logic [31:0] w_hi_word;

    assign w_o        = bus.addr[1:0];
    assign w_idx_full = {1'b0, bus.addr[31:2]};
    assign w_idx      = bus.addr[IDX_W+1:2];
    assign w_idx_hi   = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
    assign w_split    = ({1'b0, w_o} + size_of(bus.DMCtrl)) > 3'd4;

    assign w_bad_ctrl  = (bus.DMCtrl == 3'b011) || (bus.DMCtrl == 3'b110) ||
                         (bus.DMCtrl == 3'b111);
    assign w_bad_store = bus.DMWR && ((bus.DMCtrl == DM_BU) || (bus.DMCtrl == DM_HU));
    assign w_oor       = w_idx_full >= 31'(DEPTH_WORDS);
    // idx+1 >= DEPTH is the same as idx >= DEPTH-1, without overflow
    assign w_oor_hi    = w_split && (w_idx_full >= 31'(DEPTH_WORDS - 1));
    assign w_err       = w_bad_ctrl || w_bad_store || w_oor || w_oor_hi;

    // r_req_ready is only high in IDLE, so this is the acceptance edge
    assign w_accept = bus.req_valid && r_req_ready;
    assign w_wr_lo  = w_accept && !w_err && bus.DMWR;
    assign w_wr_hi  = (r_state == ST_ACC2) && r_we;

    // Aligner sees the live request in IDLE and the captured one in ACC2
    always_comb begin
        w_al_o     = w_o;
        w_al_ctrl  = bus.DMCtrl;
        w_al_wdata = bus.wdata;
        w_al_dword = {32'h0000_0000, r_mem[w_idx]};
        if (r_state == ST_ACC2) begin
            w_al_o     = r_o;
            w_al_ctrl  = r_ctrl;
            w_al_wdata = r_wdata;
            w_al_dword = {r_mem[w_idx_hi], r_w0};
        end else begin
            w_al_o     = w_o;
            w_al_ctrl  = bus.DMCtrl;
            w_al_wdata = bus.wdata;
            w_al_dword = {32'h0000_0000, r_mem[w_idx]};
        end
    end

    dm_lane_align u_align (
        .i_o     (w_al_o),
        .i_ctrl  (w_al_ctrl),
        .i_wdata (w_al_wdata),
        .i_dword (w_al_dword),
        .o_mask  (w_al_mask),
        .o_sdata (w_al_sdata),
        .o_ldata (w_al_ldata)
    );

    // Byte masks expanded to bit masks; merge keeps unmasked bytes
    assign w_bm_lo = {{8{w_al_mask[3]}}, {8{w_al_mask[2]}}, {8{w_al_mask[1]}}, {8{w_al_mask[0]}}};
    assign w_bm_hi = {{8{w_al_mask[7]}}, {8{w_al_mask[6]}}, {8{w_al_mask[5]}}, {8{w_al_mask[4]}}};
    assign w_lo_word = (w_al_dword[31:0]  & ~w_bm_lo) | (w_al_sdata[31:0]  & w_bm_lo);
    assign w_hi_word = (w_al_dword[63:32] & ~w_bm_hi) | (w_al_sdata[63:32] & w_bm_hi);

    // RAM write port: low word on acceptance, high word on the ACC2 edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_wr_lo) begin
                r_mem[w_idx] <= w_lo_word;
            end else if (w_wr_hi) begin
                r_mem[w_idx_hi] <= w_hi_word;
            end
        end
    end

    // Request capture for the second half of a split access
    always_ff @(posedge clk) begin
        if (!rst && (r_state == ST_IDLE) && w_accept) begin
            r_o     <= w_o;
            r_ctrl  <= bus.DMCtrl;
            r_we    <= bus.DMWR;
            r_idx   <= w_idx;
            r_w0    <= w_al_dword[31:0];
            r_wdata <= bus.wdata;
        end
    end

    // Control FSM and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'h0000_0000;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        if (w_err) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_err       <= 1'b1;
                            r_rdata     <= 32'h0000_0000;
                        end else if (w_split) begin
                            r_state <= ST_ACC2;
                        end else begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_err       <= 1'b0;
                            r_rdata     <= bus.DMWR ? 32'h0000_0000 : w_al_ldata;
                        end
                    end
                end
                ST_ACC2: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_err       <= 1'b0;
                    r_rdata     <= r_we ? 32'h0000_0000 : w_al_ldata;
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rdata     = r_rdata;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl. A byte-array reference memory
// computes expected load data, errors and latency from the access rules.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] ref_mem [0:4*DEPTH-1];

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Reference: returns expected rdata/err/latency and applies legal stores
    task automatic ref_apply(input bit we, input bit [2:0] ctrl, input bit [31:0] a,
                             input bit [31:0] wd, output logic [31:0] rd,
                             output bit er, output int lat);
        int n;
        longint idx;
        int o;
        bit split;
        logic [31:0] v;
        n     = (ctrl == 3'd0 || ctrl == 3'd4) ? 1 : (ctrl == 3'd1 || ctrl == 3'd5) ? 2 : 4;
        idx   = longint'(a) / 4;
        o     = int'(a % 4);
        split = (o + n) > 4;
        er    = (ctrl == 3'd3) || (ctrl >= 3'd6) || (we && ctrl >= 3'd4) ||
                (idx >= DEPTH) || (split && idx + 1 >= DEPTH);
        lat   = (er || !split) ? 1 : 2;
        rd    = 32'h0;
        if (!er) begin
            if (we) begin
                for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) v = v | (32'(ref_mem[int'(a) + k]) << (8*k));
                if (ctrl == 3'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
                if (ctrl == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
                rd = v;
            end
        end
    endtask

    // Drive one request and observe its response (no checking here)
    task automatic xact(input bit we, input bit [2:0] ctrl, input bit [31:0] a,
                        input bit [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output logic rdy_pre, output logic rdy_post,
                        output logic rsp_after);
        @(negedge clk);
        rdy_pre       = bus.req_ready;
        bus.req_valid = 1'b1;
        bus.DMWR      = we;
        bus.DMCtrl    = ctrl;
        bus.addr      = a;
        bus.wdata     = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.addr      = $urandom();
        bus.wdata     = $urandom();
        bus.DMWR      = 1'($urandom_range(0, 1));
        bus.DMCtrl    = 3'($urandom_range(0, 7));
        rdy_post      = bus.req_ready;
        lat           = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus.rdata;
        er = bus.err;
        @(posedge clk);
        #1;
        rsp_after = bus.rsp_valid;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.DMWR      = 1'b0;
        bus.DMCtrl    = 3'd0;
        bus.addr      = 32'h0;
        bus.wdata     = 32'h0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%b exp=0", bus.rsp_valid); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Give known contents to every word the later tests can reach
    task automatic test_init();
        logic [31:0] rd, erd; logic er, rp, rq, ra; bit eer; int lat, elat;
        bit [31:0] a, wd;
        for (int w = 0; w < 69; w++) begin
            a  = (w < 65) ? 32'(w * 4) : 32'((DEPTH - 4 + (w - 65)) * 4);
            wd = $urandom();
            ref_apply(1'b1, 3'd2, a, wd, erd, eer, elat);
            xact(1'b1, 3'd2, a, wd, rd, er, lat, rp, rq, ra);
            total++;
            if (er !== eer || lat != elat || rd !== erd) begin
                bad++; $display("FAIL init_sw a=%h err=%b/%b lat=%0d/%0d", a, er, eer, lat, elat);
            end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd, erd; logic er, rp, rq, ra; bit eer; int lat, elat;
        ref_apply(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, erd, eer, elat);
        xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat, rp, rq, ra);
        total++; if (er !== 1'b0 || lat != 1 || rd !== 32'h0) begin bad++; $display("FAIL sw_word err=%b lat=%0d rdata=%h exp 0/1/0", er, lat, rd); end
        ref_apply(1'b0, 3'd2, 32'h10, 32'h0, erd, eer, elat);
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL lw_word got=%h err=%b exp=deadbeef", rd, er); end
        total++; if (lat != 1) begin bad++; $display("FAIL lw_latency got=%0d exp=1", lat); end
        total++; if (ra !== 1'b0 || rp !== 1'b1) begin bad++; $display("FAIL rsp_pulse after=%b ready_pre=%b exp 0/1", ra, rp); end
    endtask

    task automatic test_byte();
        logic [31:0] rd, erd; logic er, rp, rq, ra; bit eer; int lat, elat;
        ref_apply(1'b1, 3'd2, 32'h10, 32'h11223344, erd, eer, elat);
        xact(1'b1, 3'd2, 32'h10, 32'h11223344, rd, er, lat, rp, rq, ra);
        ref_apply(1'b1, 3'd0, 32'h11, 32'h000000A5, erd, eer, elat);
        xact(1'b1, 3'd0, 32'h11, 32'h000000A5, rd, er, lat, rp, rq, ra);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL sb_err got=%b exp=0", er); end
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd !== 32'h1122A544) begin bad++; $display("FAIL lw_after_sb got=%h exp=1122a544", rd); end
        xact(1'b0, 3'd0, 32'h11, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd !== 32'hFFFFFFA5) begin bad++; $display("FAIL lb_sext got=%h exp=ffffffa5", rd); end
        xact(1'b0, 3'd4, 32'h11, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd !== 32'h000000A5) begin bad++; $display("FAIL lbu_zext got=%h exp=000000a5", rd); end
        xact(1'b0, 3'd1, 32'h10, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd !== 32'hFFFFA544) begin bad++; $display("FAIL lh_sext got=%h exp=ffffa544", rd); end
        xact(1'b0, 3'd5, 32'h12, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd !== 32'h00001122) begin bad++; $display("FAIL lhu_hi got=%h exp=00001122", rd); end
    endtask

    task automatic test_split();
        logic [31:0] rd, erd; logic er, rp, rq, ra; bit eer; int lat, elat;
        ref_apply(1'b1, 3'd2, 32'h1E, 32'hCAFEBABE, erd, eer, elat);
        xact(1'b1, 3'd2, 32'h1E, 32'hCAFEBABE, rd, er, lat, rp, rq, ra);
        total++; if (lat != 2 || er !== 1'b0) begin bad++; $display("FAIL split_sw lat=%0d err=%b exp 2/0", lat, er); end
        ref_apply(1'b0, 3'd2, 32'h1C, 32'h0, erd, eer, elat);
        xact(1'b0, 3'd2, 32'h1C, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd[31:16] !== 16'hBABE || rd !== erd) begin bad++; $display("FAIL split_lo_word got=%h exp=%h", rd, erd); end
        ref_apply(1'b0, 3'd2, 32'h20, 32'h0, erd, eer, elat);
        xact(1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd[15:0] !== 16'hCAFE || rd !== erd) begin bad++; $display("FAIL split_hi_word got=%h exp=%h", rd, erd); end
        xact(1'b0, 3'd2, 32'h1E, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd !== 32'hCAFEBABE || lat != 2) begin bad++; $display("FAIL split_lw got=%h lat=%0d exp=cafebabe/2", rd, lat); end
        xact(1'b0, 3'd1, 32'h1F, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd !== 32'hFFFFFEBA || lat != 2) begin bad++; $display("FAIL split_lh got=%h lat=%0d exp=fffffeba/2", rd, lat); end
    endtask

    task automatic test_range();
        logic [31:0] rd, erd; logic er, rp, rq, ra; bit eer; int lat, elat;
        xact(1'b0, 3'd2, 32'h1000, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin bad++; $display("FAIL oor_lw err=%b rdata=%h lat=%0d exp 1/0/1", er, rd, lat); end
        ref_apply(1'b1, 3'd2, 32'hFFE, 32'h12345678, erd, eer, elat);
        xact(1'b1, 3'd2, 32'hFFE, 32'h12345678, rd, er, lat, rp, rq, ra);
        total++; if (er !== 1'b1 || lat != 1) begin bad++; $display("FAIL oor_split_sw err=%b lat=%0d exp 1/1", er, lat); end
        ref_apply(1'b0, 3'd2, 32'hFFC, 32'h0, erd, eer, elat);
        xact(1'b0, 3'd2, 32'hFFC, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd !== erd || er !== 1'b0) begin bad++; $display("FAIL last_word_kept got=%h exp=%h", rd, erd); end
        ref_apply(1'b0, 3'd4, 32'hFFF, 32'h0, erd, eer, elat);
        xact(1'b0, 3'd4, 32'hFFF, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd !== erd || er !== 1'b0) begin bad++; $display("FAIL last_byte got=%h err=%b exp=%h/0", rd, er, erd); end
        xact(1'b0, 3'd1, 32'hFFF, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL last_half_split err=%b rdata=%h exp 1/0", er, rd); end
    endtask

    task automatic test_illegal();
        logic [31:0] rd, erd; logic er, rp, rq, ra; bit eer; int lat, elat;
        xact(1'b0, 3'd3, 32'h40, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL ctrl011_load err=%b rdata=%h exp 1/0", er, rd); end
        xact(1'b1, 3'd4, 32'h40, 32'hFFFFFFFF, rd, er, lat, rp, rq, ra);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL store_bu err=%b exp=1", er); end
        xact(1'b1, 3'd7, 32'h44, 32'hFFFFFFFF, rd, er, lat, rp, rq, ra);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL store_111 err=%b exp=1", er); end
        ref_apply(1'b0, 3'd2, 32'h40, 32'h0, erd, eer, elat);
        xact(1'b0, 3'd2, 32'h40, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd !== erd || er !== 1'b0 || rp !== 1'b1) begin bad++; $display("FAIL after_illegal got=%h err=%b exp=%h/0", rd, er, erd); end
        ref_apply(1'b0, 3'd2, 32'h44, 32'h0, erd, eer, elat);
        xact(1'b0, 3'd2, 32'h44, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd !== erd) begin bad++; $display("FAIL illegal_no_write got=%h exp=%h", rd, erd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; logic er, rp, rq, ra; bit eer; int lat, elat;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.DMWR      = 1'b1;
        bus.DMCtrl    = 3'd2;
        bus.addr      = 32'h1E;
        bus.wdata     = 32'h55667788;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL midrst_state rsp=%b ready=%b exp 0/1", bus.rsp_valid, bus.req_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_rsp got=%b exp=0", bus.rsp_valid); end
        ref_mem[32'h1E] = 8'h88;
        ref_mem[32'h1F] = 8'h77;
        ref_apply(1'b0, 3'd2, 32'h1C, 32'h0, erd, eer, elat);
        xact(1'b0, 3'd2, 32'h1C, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd[31:16] !== 16'h7788 || rd !== erd) begin bad++; $display("FAIL midrst_first got=%h exp=%h", rd, erd); end
        ref_apply(1'b0, 3'd2, 32'h20, 32'h0, erd, eer, elat);
        xact(1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat, rp, rq, ra);
        total++; if (rd[15:0] !== 16'hCAFE || rd !== erd) begin bad++; $display("FAIL midrst_second got=%h exp=%h", rd, erd); end
    endtask

    // req_valid held high: one acceptance every 2 cycles
    task automatic test_back_to_back();
        logic [31:0] erd; bit eer; int elat; int nrsp;
        ref_apply(1'b0, 3'd2, 32'h10, 32'h0, erd, eer, elat);
        nrsp = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.DMWR      = 1'b0;
        bus.DMCtrl    = 3'd2;
        bus.addr      = 32'h10;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid === 1'b1) begin
                nrsp++;
                total++; if (bus.rdata !== erd) begin bad++; $display("FAIL b2b_data got=%h exp=%h", bus.rdata, erd); end
            end
        end
        bus.req_valid = 1'b0;
        total++; if (nrsp != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", nrsp); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd; logic er, rp, rq, ra; bit eer; int lat, elat;
        bit we; bit [2:0] ctrl; bit [31:0] a, wd;
        bit [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        int sel;
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      a = 32'($urandom_range(0, 255));
            else if (sel < 9) a = 32'h0FF0 + 32'($urandom_range(0, 15));
            else              a = 32'h1000 + 32'($urandom_range(0, 64));
            ctrl = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom();
            ref_apply(we, ctrl, a, wd, erd, eer, elat);
            xact(we, ctrl, a, wd, rd, er, lat, rp, rq, ra);
            total++;
            if (rd !== erd || er !== eer || lat != elat || ra !== 1'b0 || rq !== 1'b0) begin
                bad++;
                $display("FAIL rand_%0d we=%b ctrl=%0d a=%h rdata=%h/%h err=%b/%b lat=%0d/%0d", i, we, ctrl, a, rd, erd, er, eer, lat, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_word();
        test_byte();
        test_split();
        test_range();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
